// File: rtl/conv_out_writer_param_3_if.sv
// ---------------------------------------------------------------------------
// conv_out_writer_param_3_if
// Bus between the layer-3 conv control path and the output-feature writer.
//   Control side (master drives): enable, start, result_valid, accum_result_all
//   Memory side (slave drives)  : out_feature_addr/data/wren/rden,
//                                 busy, write_done, overflow
// Map m of a group sits at accum_result_all[m*ACC_WIDTH +: ACC_WIDTH].
// ---------------------------------------------------------------------------
interface conv_out_writer_param_3_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int ACC_WIDTH      = 32,
    parameter int NUM_ONEMULT    = 4,
    parameter int OUT_ADDR_WIDTH = 10
);
    logic                              enable;
    logic                              start;
    logic                              result_valid;
    logic [ACC_WIDTH*NUM_ONEMULT-1:0]  accum_result_all;
    logic [OUT_ADDR_WIDTH-1:0]         out_feature_addr;
    logic [DATA_WIDTH-1:0]             out_feature_data;
    logic                              out_feature_wren;
    logic                              out_feature_rden;
    logic                              busy;
    logic                              write_done;
    logic                              overflow;

    modport master (
        output enable, start, result_valid, accum_result_all,
        input  out_feature_addr, out_feature_data, out_feature_wren,
               out_feature_rden, busy, write_done, overflow
    );

    modport slave (
        input  enable, start, result_valid, accum_result_all,
        output out_feature_addr, out_feature_data, out_feature_wren,
               out_feature_rden, busy, write_done, overflow
    );
endinterface

// File: rtl/conv_out_writer_param_3.sv
// ---------------------------------------------------------------------------
// conv_out_writer_param_3
// Captures each finished accumulator group (NUM_ONEMULT maps, one pixel each),
// converts every value (ReLU, arithmetic shift, saturation) and writes them one
// per cycle into the output-feature memory, map-major:
//   addr = map_idx * OUT_FEATURE_WIDTH^2 + pixel_cnt
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-high
//   bus    - conv_out_writer_param_3_if.slave (handshake, write port, status)
// Status: busy while a group is being written, write_done (sticky) once every
// pixel of every map is stored, overflow (sticky) when a group had to be dropped.
// ---------------------------------------------------------------------------
module conv_out_writer_param_3 #(
    parameter int DATA_WIDTH        = 16,
    parameter int ACC_WIDTH         = 32,
    parameter int NUM_ONEMULT       = 4,
    parameter int OUT_FEATURE_WIDTH = 8,
    parameter int FRAC_SHIFT        = 8,
    parameter int OUT_ADDR_WIDTH    = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    conv_out_writer_param_3_if.slave   bus
);

    localparam int PIXELS = OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH;
    localparam int MAP_W  = (NUM_ONEMULT > 1) ? $clog2(NUM_ONEMULT) : 1;
    localparam int PIX_W  = $clog2(PIXELS + 1);

    localparam logic [MAP_W-1:0]            LAST_MAP = MAP_W'(NUM_ONEMULT - 1);
    localparam logic [PIX_W-1:0]            LAST_PIX = PIX_W'(PIXELS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX  = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                           r_state;
    logic [MAP_W-1:0]                 r_map_idx;
    logic [PIX_W-1:0]                 r_pixel_cnt;
    logic [ACC_WIDTH*NUM_ONEMULT-1:0] r_capture;
    logic [OUT_ADDR_WIDTH-1:0]        r_addr;
    logic [DATA_WIDTH-1:0]            r_data;
    logic                             r_wren;
    logic                             r_write_done;
    logic                             r_overflow;

    logic                             w_valid;
    logic signed [ACC_WIDTH-1:0]      w_acc;
    logic signed [ACC_WIDTH-1:0]      w_shifted;
    logic [DATA_WIDTH-1:0]            w_data;
    logic [OUT_ADDR_WIDTH-1:0]        w_addr;

    // A result_valid only counts while the control path runs and we are enabled.
    assign w_valid   = bus.result_valid & bus.start & bus.enable;

    assign w_acc     = r_capture[int'(r_map_idx) * ACC_WIDTH +: ACC_WIDTH];
    assign w_shifted = w_acc >>> FRAC_SHIFT;
    assign w_addr    = OUT_ADDR_WIDTH'(int'(r_map_idx) * PIXELS + int'(r_pixel_cnt));

    always_comb begin
        // NOTE: default assignment first so every path drives w_data (no latch).
        w_data = '0;
        if (w_acc[ACC_WIDTH-1]) begin
            w_data = '0;                             // ReLU
        end else if (w_shifted > SAT_MAX) begin
            w_data = SAT_MAX[DATA_WIDTH-1:0];        // positive saturation
        end else begin
            w_data = w_shifted[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the capture register is reset like any other state; it is a
            // plain register bank, not a RAM, so the reset costs nothing special.
            r_state      <= S_IDLE;
            r_map_idx    <= '0;
            r_pixel_cnt  <= '0;
            r_capture    <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_wren       <= 1'b0;
            r_write_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the
            // pre-edge state (old capture is written while the new one is latched).
            r_wren <= 1'b0;

            if (r_state == S_DONE) begin
                r_write_done <= 1'b1;
            end

            if (bus.enable) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state <= S_WAIT;
                        end
                    end

                    S_WAIT: begin
                        if (w_valid) begin
                            r_capture <= bus.accum_result_all;
                            r_map_idx <= '0;
                            r_state   <= S_WRITE;
                        end
                    end

                    S_WRITE: begin
                        r_wren <= 1'b1;
                        r_addr <= w_addr;
                        r_data <= w_data;
                        if (r_map_idx == LAST_MAP) begin
                            r_map_idx   <= '0;
                            r_pixel_cnt <= r_pixel_cnt + PIX_W'(1);
                            if (r_pixel_cnt == LAST_PIX) begin
                                r_state <= S_DONE;
                            end else if (w_valid) begin
                                // Back-to-back group: stay in WRITE, restart at map 0.
                                r_capture <= bus.accum_result_all;
                            end else begin
                                r_state <= S_WAIT;
                            end
                        end else begin
                            r_map_idx <= r_map_idx + MAP_W'(1);
                            if (w_valid) begin
                                // No room for a second group: drop it, flag it.
                                r_overflow <= 1'b1;
                            end
                        end
                    end

                    S_DONE: begin
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.out_feature_addr = r_addr;
    assign bus.out_feature_data = r_data;
    assign bus.out_feature_wren = r_wren;
    assign bus.out_feature_rden = 1'b0;
    assign bus.busy             = (r_state == S_WRITE);
    assign bus.write_done       = r_write_done;
    assign bus.overflow         = r_overflow;

endmodule
